// File: rtl/exp2_pipe.sv
// Fixed-point base-2 antilog, out ~= 2^in, using the Mitchell approximation 2^(n+f) ~= (1+f) << n.
// Three pipeline stages with valid/ready on both sides; the result saturates high or flushes to zero.
module exp2_pipe #(
  parameter int Bf              = 8,
  parameter int FIX_POINT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FIX_POINT_WIDTH-1:0] in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIX_POINT_WIDTH-1:0] out,
  output logic                       ovf,
  output logic                       unf
);

  localparam int W     = FIX_POINT_WIDTH;
  localparam int NW    = W - Bf;
  localparam int MAX_N = W - 1 - Bf;

  // Handshake: a word moves on valid && ready at a rising edge. All stages shift
  // together when advance=1 and hold data+valid when advance=0. in_ready is
  // independent of in_valid, and the output holds steady while out_valid && !out_ready.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1: register the input word.
  logic         s1_valid;
  logic [W-1:0] s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_data  <= in;
    end
  end

  // Stage 2: split into a signed integer part and a fraction, then range-check.
  logic signed [NW-1:0] s1_n;
  logic [Bf-1:0]        s1_f;
  logic                 s1_ovf;
  logic                 s1_unf;

  always_comb begin
    s1_n   = s1_data[W-1:Bf];
    s1_f   = s1_data[Bf-1:0];
    s1_ovf = int'(s1_n) > MAX_N;
    s1_unf = int'(s1_n) < -Bf;
  end

  logic                 s2_valid;
  logic signed [NW-1:0] s2_n;
  logic [Bf:0]          s2_m;
  logic                 s2_ovf;
  logic                 s2_unf;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_n     <= '0;
      s2_m     <= '0;
      s2_ovf   <= 1'b0;
      s2_unf   <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_n     <= s1_n;
      s2_m     <= {1'b1, s1_f};
      s2_ovf   <= s1_ovf;
      s2_unf   <= s1_unf;
    end
  end

  // Stage 3: shift the mantissa by the integer part; right shifts truncate.
  logic [W-1:0]  m_ext;
  logic [NW-1:0] neg_n;
  logic [W-1:0]  res;
  logic          res_ovf;
  logic          res_unf;

  always_comb begin
    m_ext   = {{(W-Bf-1){1'b0}}, s2_m};
    neg_n   = -s2_n;
    res     = '0;
    res_ovf = 1'b0;
    res_unf = 1'b0;
    if (s2_ovf) begin
      res     = '1;
      res_ovf = 1'b1;
    end else if (s2_unf) begin
      res_unf = 1'b1;
    end else if (!s2_n[NW-1]) begin
      res = m_ext << s2_n;
    end else begin
      res = m_ext >> neg_n;
    end
  end

  // Bubbles leave zeros on out/ovf/unf so nothing stale is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      out       <= s2_valid ? res : '0;
      ovf       <= s2_valid && res_ovf;
      unf       <= s2_valid && res_unf;
    end
  end

endmodule

// File: tb/tb_exp2_pipe.sv
// Directed bench for exp2_pipe (16-bit, 8 fractional bits): single words, streaming,
// output stall and mid-stream reset, with hand-computed expected results.
module tb_exp2_pipe;

  localparam int W  = 16;
  localparam int BF = 8;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;
  logic         ovf;
  logic         unf;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];

  logic [W-1:0] b2b_in  [4] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300};
  logic [W-1:0] b2b_exp [4] = '{16'h0100, 16'h0200, 16'h0400, 16'h0800};
  logic [W-1:0] st_in   [6] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
  logic [W-1:0] st_exp  [6] = '{16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000};

  exp2_pipe #(.Bf(BF), .FIX_POINT_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Send one word into an empty pipeline and check the exact 3-cycle latency.
  task automatic send_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] e,
                          input logic eo, input logic eu);
    @(negedge clk);
    din = x; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, ".in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, ".lat1"}, out_valid, 0);
    @(negedge clk);
    #1 chk({tag, ".lat2"}, out_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".out"}, dout, e);
    chk({tag, ".ovf"}, ovf, eo);
    chk({tag, ".unf"}, unf, eu);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    int pops;

    rst = 1'b1; in_valid = 1'b0; din = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst.in_ready",  in_ready,  1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out",       dout,      0);
    chk("rst.ovf",       ovf,       0);
    chk("rst.unf",       unf,       0);

    send_one("zero",     16'h0000, 16'h0100, 1'b0, 1'b0);
    send_one("one_half", 16'h0180, 16'h0300, 1'b0, 1'b0);
    send_one("neg_one",  16'hFF00, 16'h0080, 1'b0, 1'b0);
    send_one("half",     16'h0080, 16'h0180, 1'b0, 1'b0);
    send_one("neg_frac", 16'hFE40, 16'h0050, 1'b0, 1'b0);
    send_one("max_n",    16'h0700, 16'h8000, 1'b0, 1'b0);
    send_one("max_n_f",  16'h07FF, 16'hFF80, 1'b0, 1'b0);
    send_one("ovf8",     16'h0800, 16'hFFFF, 1'b1, 1'b0);
    send_one("ovf_big",  16'h7FFF, 16'hFFFF, 1'b1, 1'b0);
    send_one("min_n",    16'hF800, 16'h0001, 1'b0, 1'b0);
    send_one("min_n_f",  16'hF8FF, 16'h0001, 1'b0, 1'b0);
    send_one("unf9",     16'hF700, 16'h0000, 1'b0, 1'b1);
    send_one("most_neg", 16'h8000, 16'h0000, 1'b0, 1'b1);

    // Back-to-back stream: results on 4 consecutive cycles.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (k >= 3 && k <= 6) begin
        chk($sformatf("b2b.valid%0d", k - 3), out_valid, 1);
        chk($sformatf("b2b.out%0d", k - 3), dout, b2b_exp[k-3]);
      end else begin
        chk($sformatf("b2b.idle%0d", k), out_valid, 0);
      end
      if (k < 4) begin
        din = b2b_in[k]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end

    // Output stall for 5 cycles mid-stream.
    acc = 0; pops = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 8);
      in_valid  = (acc < 6);
      din       = (acc < 6) ? st_in[acc] : '0;
      #1;
      if (c >= 4 && c <= 8) begin
        chk($sformatf("stall.in_ready%0d", c), in_ready, 0);
        chk($sformatf("stall.valid%0d", c), out_valid, 1);
        chk($sformatf("stall.hold%0d", c), dout, exp_q[0]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("stall.extra%0d", c), out_valid, 0);
        end else begin
          chk($sformatf("stall.pop%0d", pops), dout, exp_q.pop_front());
          pops++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(st_exp[acc]);
        acc++;
      end
    end
    in_valid = 1'b0;
    chk("stall.pops", pops, 6);
    chk("stall.left", exp_q.size(), 0);

    // Reset with three words in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; din = 16'h0800;
    @(negedge clk);
    din = 16'h0100;
    @(negedge clk);
    din = 16'h0200;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid.pre_valid", out_valid, 1);
    chk("mid.pre_out",   dout,      16'hFFFF);
    chk("mid.pre_ovf",   ovf,       1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid.valid", out_valid, 0);
    chk("mid.out",   dout,      0);
    chk("mid.ovf",   ovf,       0);
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk($sformatf("mid.drop%0d", k), out_valid, 0);
    end
    send_one("post_rst", 16'h0180, 16'h0300, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
